instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Inverse of the main decoder. Accepts symbolic instruction descriptors over a valid/ready handshake and encodes each into a 32-bit MIPS word. Supported operations are R-type, JR, LW, SW, BEQ, ADDI, J and JAL. Encoded words are written sequentially into instruction memory through a registered write port. The block is used by benches and boot logic to load programs that the single-cycle core then fetches and decodes.

Parameters:
AW, 6, imem word-address width.
DEPTH, 64, maximum words per load (at most 2**AW).
BASE, 0, first word address written after start.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a new load; honoured in IDLE, DONE and ERROR, ignored in LOAD and FLUSH
in_valid  in  1  descriptor valid
in_ready  out  1  block can accept a descriptor
in_op  in  instr_kind_t  operation kind
in_rs, in_rt, in_rd  in  5 each  register fields
in_funct  in  funct_t  R-type function code
in_imm  in  16  immediate or branch offset
in_target  in  26  jump target field
in_last  in  1  final descriptor of the program
imem_we  out  1  write strobe
imem_addr  out  AW  word address
imem_wd  out  32  encoded instruction
busy  out  1  state is LOAD or FLUSH
done  out  1  load completed without error
err  out  1  sticky error flag
err_code  out  2  01 = bad op, 10 = overflow
count  out  AW+1  number of words written in the current load

Behaviour:
- Reset: state=IDLE; in_ready=0; imem_we=0; imem_addr=0; imem_wd=0; busy=0; done=0; err=0; err_code=0; count=0.
- Reset mid-load drops the pending write and returns to IDLE. No further imem_we occurs.
- States are IDLE, LOAD, FLUSH, DONE, ERROR. in_ready=1 only in LOAD.
- start (from IDLE, DONE or ERROR) -> LOAD next cycle. On entry: addr pointer=BASE, count=0, done=0, err=0, err_code=0.
- Handshake: a descriptor is accepted on any edge where in_valid & in_ready. A descriptor accepted at cycle N appears as imem_we=1 with imem_addr/imem_wd during cycle N+1, for exactly one cycle. Back-to-back accepts give one write per cycle.
- After each write, the address pointer increments by 1 and count increments by 1. Address arithmetic is modulo 2**AW.
- Encoding (shamt is always 0):
  - RTYPE = {6'b000000, rs, rt, rd, 5'b0, funct}
  - JR = {6'b0, rs, 15'b0, F_JR}
  - LW/SW/BEQ/ADDI = {opcode, rs, rt, imm}
  - J/JAL = {opcode, target}
- Accepted descriptor with in_last=1: next state FLUSH, in which the final write is issued. FLUSH -> DONE. done=1 from the cycle after the last imem_we, and holds until start or reset.
- Bad op (in_op not a legal instr_kind_t, or RTYPE with funct=F_JR): accepted, not written, count unchanged. Next state is ERROR with err=1, err_code=01.
- Overflow: accepting descriptor number DEPTH (count==DEPTH-1) without in_last causes that word to be written, then the state goes to ERROR with err_code=10. in_ready drops at the same time.
- Bad op together with in_last: bad op takes priority.
- ERROR is sticky until start or reset. done stays 0 in ERROR.

Decomposition:
- Add to mips_decls_p:
  - instr_kind_t enum: K_RTYPE, K_JR, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_JAL.
  - loader state enum.
  - err-code constants.
- Reuse the existing opcode_t/funct_t values (OP_*, F_JR).
- One natural sub-module: instr_encoder, purely combinational, mapping descriptor -> {word, bad_op}.
- The top level holds the FSM, the output register and the counters.

Test Plan:
- start; add rs=8, rt=9, rd=10, funct=0x20, in_last=1 -> one write: imem_addr=0, imem_wd=0x01095020. done=1 two cycles after the accept.
- Back-to-back stream with in_valid held high:
  - lw rs=29, rt=16, imm=4 -> addr 0, word 0x8FB00004
  - beq rs=8, rt=0, imm=0xFFFF -> addr 1, word 0x1100FFFF
  - jr rs=31 -> addr 2, word 0x03E00008
  - j target=0x0100008, last -> addr 3, word 0x08100008
  - Required: writes on consecutive cycles, final count=4.
- Stall: in_valid toggled 1-0-1 -> imem_we asserted only for accepted beats; addresses contiguous.
- Bad op: in_op set to an illegal encoding mid-load -> no write, err=1, err_code=01, in_ready=0. A subsequent start clears the error and restarts at BASE.
- Overflow: DEPTH=4, five descriptors with no last -> 4 writes (addresses 0-3), err_code=10, fifth descriptor never accepted.
- Reset asserted in the cycle after an accept -> no imem_we, all outputs return to their reset values.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared MIPS opcode/funct values plus the descriptor and loader-state types
// used by the instruction encoder/loader slice.
package instr_encoder_loader_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef logic [5:0] funct_t;
  localparam funct_t F_JR  = 6'h08;
  localparam funct_t F_ADD = 6'h20;

  // Four bits wide so that out-of-range kinds are representable and flagged.
  typedef enum logic [3:0] {
    K_RTYPE = 4'd0,
    K_JR    = 4'd1,
    K_LW    = 4'd2,
    K_SW    = 4'd3,
    K_BEQ   = 4'd4,
    K_ADDI  = 4'd5,
    K_J     = 4'd6,
    K_JAL   = 4'd7
  } instr_kind_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } loader_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BAD_OP   = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  function automatic logic [31:0] enc_itype(input opcode_t op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Descriptor handshake plus instruction-memory write port of the loader.
// valid/ready: a descriptor transfers on every rising edge where in_valid && in_ready;
// the source holds all in_* fields stable while in_valid is high and not yet accepted.
interface instr_encoder_loader_if #(parameter int AW = 6);
  import instr_encoder_loader_pkg::*;

  logic          in_valid;
  logic          in_ready;
  instr_kind_t   in_op;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  funct_t        in_funct;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
    input  in_ready, imem_we, imem_addr, imem_wd
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
    output in_ready, imem_we, imem_addr, imem_wd
  );

endinterface

// File: rtl/instr_encoder_loader_enc.sv
// Combinational descriptor -> 32-bit MIPS word encoder; shamt is always zero.
module instr_encoder
  import instr_encoder_loader_pkg::*;
(
  input  instr_kind_t op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  funct_t      funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        bad_op
);

  always_comb begin
    word   = 32'h0;
    bad_op = 1'b0;
    case (op)
      K_RTYPE: begin
        word = {OP_RTYPE, rs, rt, rd, 5'b0, funct};
        // JR has its own kind; an R-type carrying F_JR is malformed.
        bad_op = (funct == F_JR);
      end
      K_JR:   word = {OP_RTYPE, rs, 15'b0, F_JR};
      K_LW:   word = enc_itype(OP_LW, rs, rt, imm);
      K_SW:   word = enc_itype(OP_SW, rs, rt, imm);
      K_BEQ:  word = enc_itype(OP_BEQ, rs, rt, imm);
      K_ADDI: word = enc_itype(OP_ADDI, rs, rt, imm);
      K_J:    word = {OP_J, target};
      K_JAL:  word = {OP_JAL, target};
      default: bad_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes accepted descriptors and writes them sequentially into
// instruction memory through a registered write port, tracking count/done/error.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int AW    = 6,
  parameter int DEPTH = 64,
  parameter int BASE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [AW:0]           count,
  output loader_state_t         state_dbg
);

  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
  localparam logic [AW:0]   LAST_IDX  = (AW+1)'(DEPTH - 1);

  loader_state_t state;
  logic          ready_r;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   wd_r;
  logic [AW-1:0] ptr;
  logic [AW:0]   count_r;
  logic          done_r;
  logic          err_r;
  logic [1:0]    code_r;

  logic [31:0]   enc_word;
  logic          enc_bad;
  logic          accept;

  instr_encoder u_enc (
    .op     (bus.in_op),
    .rs     (bus.in_rs),
    .rt     (bus.in_rt),
    .rd     (bus.in_rd),
    .funct  (bus.in_funct),
    .imm    (bus.in_imm),
    .target (bus.in_target),
    .word   (enc_word),
    .bad_op (enc_bad)
  );

  assign accept = bus.in_valid & ready_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wd_r    <= '0;
      ptr     <= '0;
      count_r <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      code_r  <= ERR_NONE;
    end else begin
      we_r <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state   <= S_LOAD;
            ready_r <= 1'b1;
            ptr     <= BASE_ADDR;
            count_r <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            code_r  <= ERR_NONE;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (enc_bad) begin
              state   <= S_ERROR;
              ready_r <= 1'b0;
              err_r   <= 1'b1;
              code_r  <= ERR_BAD_OP;
            end else begin
              we_r    <= 1'b1;
              addr_r  <= ptr;
              wd_r    <= enc_word;
              ptr     <= ptr + 1'b1;
              count_r <= count_r + 1'b1;
              if (bus.in_last) begin
                state   <= S_FLUSH;
                ready_r <= 1'b0;
              end else if (count_r == LAST_IDX) begin
                // This word still lands; nothing more fits after it.
                state   <= S_ERROR;
                ready_r <= 1'b0;
                err_r   <= 1'b1;
                code_r  <= ERR_OVERFLOW;
              end
            end
          end
        end
        S_FLUSH: begin
          state  <= S_DONE;
          done_r <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A write pending when reset rises is suppressed rather than emitted.
  assign bus.imem_we   = we_r & ~reset;
  assign bus.imem_addr = addr_r;
  assign bus.imem_wd   = wd_r;
  assign bus.in_ready  = ready_r;

  assign busy      = (state == S_LOAD) || (state == S_FLUSH);
  assign done      = done_r;
  assign err       = err_r;
  assign err_code  = code_r;
  assign count     = count_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with an address/word scoreboard.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  localparam int AW    = 6;
  localparam int DEPTH = 4;
  localparam int BASE  = 0;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   count;
  loader_state_t state_dbg;

  instr_encoder_loader_if #(.AW(AW)) bus ();

  instr_encoder_loader #(.AW(AW), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .count     (count),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int prev_cyc = 0;
  int gap_err  = 0;
  logic have_prev  = 1'b0;
  logic track_gap  = 1'b0;
  logic [AW-1:0] exp_addr;
  logic [AW+31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // scoreboard: every visible write must match the oldest expectation
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      logic [AW+31:0] e;
      wr_cnt++;
      if (track_gap) begin
        if (have_prev && (cyc - prev_cyc != 1)) gap_err++;
        have_prev = 1'b1;
        prev_cyc  = cyc;
      end
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("imem_addr", 64'(bus.imem_addr), 64'(e[AW+31:32]));
        check("imem_wd", 64'(bus.imem_wd), 64'(e[31:0]));
      end
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
    exp_addr = AW'(BASE);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input instr_kind_t op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last, input logic exp_write,
                      input logic [31:0] exp_word, output logic acc);
    bus.in_op     = op;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_funct  = funct;
    bus.in_imm    = imm;
    bus.in_target = tgt;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 6 && !acc; i++) begin
      acc = bus.in_ready;
      if (acc && exp_write) begin
        exp_q.push_back({exp_addr, exp_word});
        exp_addr = exp_addr + 1'b1;
      end
      cycle();
    end
  endtask

  task automatic drain();
    cycle();
    cycle();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic acc;
    int   w0;
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = K_RTYPE;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.in_rd     = '0;
    bus.in_funct  = '0;
    bus.in_imm    = '0;
    bus.in_target = '0;
    bus.in_last   = 1'b0;
    exp_addr      = '0;
    repeat (3) cycle();
    check("rst_ready", 64'(bus.in_ready), 64'd0);
    check("rst_we", 64'(bus.imem_we), 64'd0);
    check("rst_addr", 64'(bus.imem_addr), 64'd0);
    check("rst_wd", 64'(bus.imem_wd), 64'd0);
    check("rst_busy_done_err", 64'({busy, done, err, err_code}), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(S_IDLE));
    reset = 1'b0;
    cycle();

    // single add
    do_start();
    check("start_ready", 64'(bus.in_ready), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    send(K_RTYPE, 5'd8, 5'd9, 5'd10, F_ADD, 16'h0, 26'h0, 1'b1, 1'b1, 32'h01095020, acc);
    idle();
    check("add_acc", 64'(acc), 64'd1);
    check("add_done_early", 64'(done), 64'd0);
    check("add_ready_low", 64'(bus.in_ready), 64'd0);
    cycle();
    check("add_done", 64'(done), 64'd1);
    check("add_count", 64'(count), 64'd1);
    check("add_busy", 64'(busy), 64'd0);
    cycle();
    check("done_hold", 64'(done), 64'd1);
    drain();

    // back-to-back stream
    do_start();
    check("restart_done_clr", 64'(done), 64'd0);
    w0 = wr_cnt;
    track_gap = 1'b1;
    have_prev = 1'b0;
    send(K_LW, 5'd29, 5'd16, 5'd0, 6'd0, 16'h0004, 26'h0, 1'b0, 1'b1, 32'h8FB00004, acc);
    send(K_BEQ, 5'd8, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0, 1'b0, 1'b1, 32'h1100FFFF, acc);
    send(K_JR, 5'd31, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h03E00008, acc);
    send(K_J, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0100008, 1'b1, 1'b1, 32'h08100008, acc);
    idle();
    drain();
    track_gap = 1'b0;
    check("b2b_writes", 64'(wr_cnt - w0), 64'd4);
    check("b2b_gap", 64'(gap_err), 64'd0);
    check("b2b_count", 64'(count), 64'd4);
    check("b2b_done", 64'({done, err}), 64'b10);

    // stalled source
    do_start();
    w0 = wr_cnt;
    send(K_RTYPE, 5'd1, 5'd2, 5'd3, F_ADD, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221820, acc);
    idle();
    cycle();
    send(K_ADDI, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'h0, 1'b0, 1'b1, 32'h20220005, acc);
    idle();
    cycle();
    cycle();
    send(K_SW, 5'd29, 5'd31, 5'd0, 6'd0, 16'h0008, 26'h0, 1'b1, 1'b1, 32'hAFBF0008, acc);
    idle();
    drain();
    check("stall_writes", 64'(wr_cnt - w0), 64'd3);
    check("stall_count", 64'(count), 64'd3);

    // illegal kind mid-load
    do_start();
    w0 = wr_cnt;
    send(K_JAL, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000010, 1'b0, 1'b1, 32'h0C000010, acc);
    send(instr_kind_t'(4'hF), 5'd1, 5'd1, 5'd1, 6'd0, 16'h1, 26'h0, 1'b0, 1'b0, 32'h0, acc);
    idle();
    check("bad_acc", 64'(acc), 64'd1);
    check("bad_err", 64'({err, err_code}), 64'b101);
    check("bad_ready", 64'(bus.in_ready), 64'd0);
    drain();
    check("bad_writes", 64'(wr_cnt - w0), 64'd1);
    check("bad_count", 64'(count), 64'd1);
    check("bad_state", 64'(state_dbg), 64'(S_ERROR));
    check("bad_done", 64'(done), 64'd0);

    // R-type with F_JR and last: bad op wins
    do_start();
    check("restart_err_clr", 64'({err, err_code}), 64'd0);
    w0 = wr_cnt;
    send(K_RTYPE, 5'd4, 5'd5, 5'd6, F_JR, 16'h0, 26'h0, 1'b1, 1'b0, 32'h0, acc);
    idle();
    drain();
    check("rjr_err", 64'({done, err, err_code}), 64'b0101);
    check("rjr_writes", 64'(wr_cnt - w0), 64'd0);

    // restart after error begins at BASE again
    do_start();
    send(K_ADDI, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0007, 26'h0, 1'b1, 1'b1, 32'h20080007, acc);
    idle();
    drain();
    check("recover_done", 64'({done, err}), 64'b10);

    // overflow at DEPTH words
    do_start();
    w0 = wr_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      send(K_ADDI, 5'd0, 5'd9, 5'd0, 6'd0, 16'(i), 26'h0, 1'b0, 1'b1,
           32'h20090000 | 32'(i), acc);
    end
    check("ovf_ready", 64'(bus.in_ready), 64'd0);
    send(K_ADDI, 5'd0, 5'd9, 5'd0, 6'd0, 16'h00FF, 26'h0, 1'b0, 1'b0, 32'h0, acc);
    idle();
    check("ovf_fifth_acc", 64'(acc), 64'd0);
    drain();
    check("ovf_writes", 64'(wr_cnt - w0), 64'(DEPTH));
    check("ovf_err", 64'({done, err, err_code}), 64'b0110);
    check("ovf_count", 64'(count), 64'(DEPTH));

    // reset in the cycle after an accept
    do_start();
    w0 = wr_cnt;
    send(K_LW, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0010, 26'h0, 1'b0, 1'b1, 32'h8C430010, acc);
    idle();
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_we", 64'(bus.imem_we), 64'd0);
    exp_q.delete();
    cycle();
    check("rstmid_ready", 64'(bus.in_ready), 64'd0);
    check("rstmid_addr_wd", 64'({bus.imem_addr, bus.imem_wd}), 64'd0);
    check("rstmid_flags", 64'({busy, done, err, err_code}), 64'd0);
    check("rstmid_count", 64'(count), 64'd0);
    check("rstmid_state", 64'(state_dbg), 64'(S_IDLE));
    reset = 1'b0;
    cycle();
    cycle();
    check("rstmid_writes", 64'(wr_cnt - w0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
